// File: rtl/shift_pipe_if.sv
// Handshake bundle for the shift pipe: operand/op/tag in, result/tag out.
// The master drives operations and accepts results; the slave is the unit.
interface shift_pipe_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           in_data;
    logic [$clog2(N)-1:0]   in_shamt;
    logic [1:0]             in_op;
    logic [TAG_W-1:0]       in_tag;

    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0]           out_data;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage 32-bit shifter (SLL/SRL/SRA/PASS): stage 1 shifts by whole bytes,
// stage 2 by the remaining 0-7 bits; valid/ready on both sides, 1 op/cycle.
module shift_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_pipe_if.slave   bus
);
    localparam int SH_W  = $clog2(N);
    localparam int LANES = N / 8;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    // Stage-1 state
    logic             s1_valid_reg;
    op_e              s1_op_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [2:0]       s1_fine_reg;
    logic             s1_sign_reg;
    logic [N-1:0]     s1_data_reg;

    // Stage-2 (output) state
    logic             s2_valid_reg;
    logic [N-1:0]     out_data_reg;
    logic [TAG_W-1:0] out_tag_reg;
    logic             out_zero_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;

    op_e              in_op_e;
    logic [1:0]       coarse_sel;
    logic             coarse_fill;
    logic [N-1:0]     coarse_right;
    logic [N-1:0]     coarse_left;
    logic [N-1:0]     coarse_next;
    logic [N-1:0]     fine_next;

    // Handshake: a full stage may advance only if the one after it can take it.
    assign s2_adv  = !s2_valid_reg || bus.out_ready;
    assign s1_adv  = !s1_valid_reg || s2_adv;
    assign in_fire = bus.in_valid && s1_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_tag   = out_tag_reg;
    assign bus.out_zero  = out_zero_reg;

    assign in_op_e     = op_e'(bus.in_op);
    assign coarse_sel  = bus.in_shamt[SH_W-1:3];
    assign coarse_fill = (in_op_e == OP_SRA) && bus.in_data[N-1];

    // Coarse shift as a per-byte-lane mux: each output lane picks one input lane or fill.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_right;
            logic [7:0] lane_left;

            always_comb begin
                lane_right = {8{coarse_fill}};
                lane_left  = 8'h00;
                for (int j = 0; j < LANES; j++) begin
                    if (j == gi + int'(coarse_sel)) begin
                        lane_right = bus.in_data[8*j +: 8];
                    end
                    if (j + int'(coarse_sel) == gi) begin
                        lane_left = bus.in_data[8*j +: 8];
                    end
                end
            end

            assign coarse_right[8*gi +: 8] = lane_right;
            assign coarse_left[8*gi +: 8]  = lane_left;
        end
    endgenerate

    always_comb begin
        coarse_next = bus.in_data;
        case (in_op_e)
            OP_SLL:  coarse_next = coarse_left;
            OP_SRL:  coarse_next = coarse_right;
            OP_SRA:  coarse_next = coarse_right;
            default: coarse_next = bus.in_data;
        endcase
    end

    // Right shifts go through a double-width word so the upper half supplies the fill.
    function automatic logic [N-1:0] fine_shift(
        input logic [N-1:0] d,
        input logic [2:0]   amt,
        input op_e          op,
        input logic         sign
    );
        logic [2*N-1:0] ext;
        ext = {{N{sign && (op == OP_SRA)}}, d} >> amt;
        case (op)
            OP_SLL:  return d << amt;
            OP_SRL:  return ext[N-1:0];
            OP_SRA:  return ext[N-1:0];
            default: return d;
        endcase
    endfunction

    assign fine_next = fine_shift(s1_data_reg, s1_fine_reg, s1_op_reg, s1_sign_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= OP_SLL;
            s1_tag_reg   <= '0;
            s1_fine_reg  <= '0;
            s1_sign_reg  <= 1'b0;
            s1_data_reg  <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= in_op_e;
            s1_tag_reg   <= bus.in_tag;
            s1_fine_reg  <= bus.in_shamt[2:0];
            s1_sign_reg  <= bus.in_data[N-1];
            s1_data_reg  <= coarse_next;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // An empty stage 1 still loads stage 2, but only as a bubble (valid follows s1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_reg <= 1'b0;
            out_data_reg <= '0;
            out_tag_reg  <= '0;
            out_zero_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            out_data_reg <= fine_next;
            out_tag_reg  <= s1_tag_reg;
            out_zero_reg <= (fine_next == '0);
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed vectors, backpressure, reset flush
// and a randomised stream checked against a behavioural shift model.
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_pipe_if #(.N(32), .TAG_W(4)) bus ();

    shift_pipe #(.N(32), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        zero;
        int          due;
    } item_t;

    item_t exp_q[$];
    item_t mon_item;
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    bit    rand_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    // Monitor: an output transfer happens at the next rising edge when valid && ready now.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %0d data 0x%08h, required no output",
                             bus.out_tag, bus.out_data);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_item.data);
                    check("out_tag", 32'(bus.out_tag), 32'(mon_item.tag));
                    check("out_zero", 32'(bus.out_zero), 32'(mon_item.zero));
                    if (mon_item.due >= 0) check("latency_cycle", 32'(cyc), 32'(mon_item.due));
                    if (!rand_mode)
                        $display("out  tag=%0d data=0x%08h zero=%0d", bus.out_tag, bus.out_data,
                                 bus.out_zero);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                        input logic [3:0] tag, input logic [31:0] expv, input bit lat);
        bit    acc = 1'b0;
        item_t it;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0, required 1 within 1000 cycles");
        end else begin
            it.data = expv;
            it.tag  = tag;
            it.zero = (expv == 32'h0);
            // accepted at the next edge; stage 2 holds it one edge later
            it.due  = lat ? cyc + 2 : -1;
            exp_q.push_back(it);
            if (!rand_mode)
                $display("in   tag=%0d op=%0d data=0x%08h shamt=%0d", tag, op, d, s);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  op;
        logic [31:0] expv;
    } vec_t;

    vec_t dir_vec[11] = '{
        '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000},
        '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001},
        '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000},
        '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000},
        '{32'hDEAD_BEEF, 5'd17, 2'b11, 32'hDEAD_BEEF},
        '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF},
        '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800},
        '{32'h1234_5678, 5'd16, 2'b01, 32'h0000_1234},
        '{32'h8000_0000, 5'd0,  2'b10, 32'h8000_0000},
        '{32'h8765_4321, 5'd24, 2'b10, 32'hFFFF_FF87},
        '{32'hA5A5_A5A5, 5'd0,  2'b00, 32'hA5A5_A5A5}
    };

    logic [31:0] srl_ones[8] = '{
        32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1FFF_FFFF,
        32'h0FFF_FFFF, 32'h07FF_FFFF, 32'h03FF_FFFF, 32'h01FF_FFFF
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [1:0]  rop;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_data", bus.out_data, 32'd0);
        check("reset_out_tag", 32'(bus.out_tag), 32'd0);
        check("reset_out_zero", 32'(bus.out_zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed functional vectors, back-to-back with out_ready high
        bus.out_ready = 1'b1;
        foreach (dir_vec[i])
            send(dir_vec[i].d, dir_vec[i].s, dir_vec[i].op, 4'(i), dir_vec[i].expv, 1'b1);
        wait_drain(50);

        // Latency and throughput: SRL of all-ones by 0..7
        for (int k = 0; k < 8; k++)
            send(32'hFFFF_FFFF, 5'(k), 2'b01, 4'(k), srl_ones[k], 1'b1);
        wait_drain(50);

        // Backpressure: two ops fill the pipe, a third waits while out_ready is low
        bus.out_ready = 1'b0;
        send(32'h8000_0000, 5'd12, 2'b10, 4'd10, 32'hFFF8_0000, 1'b0);
        send(32'h0000_000F, 5'd27, 2'b00, 4'd11, 32'h7800_0000, 1'b0);
        bus.in_data  = 32'hF000_0000;
        bus.in_shamt = 5'd12;
        bus.in_op    = 2'b01;
        bus.in_tag   = 4'd12;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_data", bus.out_data, 32'hFFF8_0000);
            check("stall_out_tag", 32'(bus.out_tag), 32'd10);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'hF000_0000, 5'd12, 2'b01, 4'd12, 32'h000F_0000, 1'b0);
        wait_drain(50);

        // Reset with two ops in flight: outputs clear immediately, nothing emerges later
        bus.out_ready = 1'b0;
        send(32'hDEAD_BEEF, 5'd3, 2'b11, 4'd1, 32'hDEAD_BEEF, 1'b0);
        send(32'h1234_5678, 5'd4, 2'b00, 4'd2, 32'h2345_6780, 1'b0);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset_out_data", bus.out_data, 32'd0);
        check("midreset_out_zero", 32'(bus.out_zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random stress: every op/shamt pair first, then random ops with idle gaps
        rand_mode = 1'b1;
        fork
            while (rand_mode) begin
                @(posedge clk);
                #1;
                if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                bus.in_shamt = 5'($urandom_range(0, 31));
                bus.in_op    = 2'($urandom_range(0, 3));
                bus.in_tag   = 4'($urandom_range(0, 15));
                @(posedge clk);
                #1;
            end
            rd = $urandom;
            if (i < 128) begin
                rop = 2'(i % 4);
                rs  = 5'(i / 4);
            end else begin
                rop = 2'($urandom_range(0, 3));
                rs  = 5'($urandom_range(0, 31));
            end
            send(rd, rs, rop, 4'(i), ref_shift(rd, rs, rop), 1'b0);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_drain(200);
        @(negedge clk);
        check("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Two-stage pipelined 32-bit shift execution unit for the ALU datapath.
- Accepts an operand, a shift amount and an opcode over a valid/ready handshake.
- Performs SLL, SRL or SRA in two steps:
  - stage 1: coarse shift by multiples of 8
  - stage 2: fine shift by 0–7
- Presents the registered result downstream with backpressure; full throughput of 1 op/cycle.

Parameters:
- N, 32, datapath width; only 32 is supported.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents an op
- in_ready  output  1  unit can accept an op this cycle
- in_data  input  N  operand
- in_shamt  input  $clog2(N)  shift amount, 0–31
- in_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=PASS
- in_tag  input  TAG_W  opaque tag, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  N  shifted result
- out_tag  output  TAG_W  tag of this result
- out_zero  output  1  out_data == 0

Behaviour:
- Reset (rst low, async): clear s1_valid, s2_valid, out_data, out_tag and out_zero to 0. The datapath registers in stage 1 also clear to 0. Ops in flight during reset are discarded. in_ready is 1 after reset.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Stall logic:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no registered skid buffer).
- Stage 1 (on an input transfer):
  - Register the opcode, tag, in_shamt[2:0] and the sign bit in_data[31].
  - Register the coarse result: in_data shifted by 8*in_shamt[4:3] per the opcode.
  - SLL and SRL fill with 0; SRA fills with in_data[31].
  - PASS registers in_data unchanged; shamt is ignored in both stages.
  - s1_valid is set to 1.
- Stage 1, no new transfer: if s1_adv is true, s1_valid clears to 0. Otherwise stage 1 holds.
- Stage 2 (when s2_adv is true):
  - Load the fine shift of the stage-1 data by the stored shamt[2:0], using the same fill rule and the stored sign.
  - Load the tag, out_zero = (result == 0), and s2_valid = s1_valid.
- Stage 2 stalled (out_valid && !out_ready): out_data, out_tag, out_zero and out_valid hold stable.
- out_valid = s2_valid.
- Latency: an op accepted at edge k is valid at out_* after edge k+2 when there is no stall.
- Throughput: back-to-back ops with out_ready held high flow 1 per cycle. Ops stay in order and none are dropped or duplicated.
- Simultaneous events:
  - Stage 1 full, stage 2 full and out_ready high in the same cycle: stage 2 takes stage 1, and stage 1 takes the new input if in_valid.
  - out_ready low with both stages full: in_ready = 0.
- Boundary conditions:
  - shamt = 0: result equals the operand for every op.
  - shamt = 31:
    - SRL gives in[31] in bit 0, all other bits 0.
    - SRA gives all bits equal to in[31].
    - SLL gives in[0] in bit 31, all other bits 0.
- Maximum occupancy is 2 ops.
- Values on in_data, in_shamt, in_op and in_tag are ignored unless in_valid && in_ready.

Test Plan:
- Reset then idle: assert rst low mid-stream with 2 ops in flight → out_valid = 0, in_ready = 1, out_data = 0 immediately. No stale result appears after release.
- Functional ops with out_ready = 1:
  - SRA 0x80000000 by 4 → 0xF8000000
  - SRL 0x80000000 by 31 → 0x00000001
  - SLL 0x00000001 by 31 → 0x80000000
  - SRA 0x7FFFFFFF by 31 → 0x00000000 with out_zero = 1
  - PASS 0xDEADBEEF with shamt 17 → 0xDEADBEEF
- Latency and throughput: 8 back-to-back SRL ops of 0xFFFFFFFF by 0..7, tags 0..7, with out_ready high → first result 2 cycles after the first accept, then one per cycle. Results are 0xFFFFFFFF>>k with matching tags in order.
- Backpressure: fill the pipe, hold out_ready low 5 cycles → in_ready = 0 after 2 accepts and out_* stays stable. On release, both results drain in order and no op is lost or duplicated.
- Random stress: 10k random ops with random in_valid and out_ready toggling, checked against a reference model (>>, <<, >>> with $signed) and a tag scoreboard → zero mismatches. Every op/shamt combination is covered, including shamt 0, 8, 16, 24 and 31.
